ram16_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for the 16x16 single-port RAM (RAM16x16).
- Accepts one command at a time via valid/ready and drives the RAM's data_in/addr_in/cs/w_en/op_en strobes for exactly one cycle.
- For reads, captures data_out after the RAM read latency; returns a one-cycle response to the granted requester.
- Sits between client blocks (e.g. DMA, CPU port) and the RAM macro.

---
 rtl/ram16_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ram16_arbiter.sv
// rtl/ram16_arbiter.sv - two-requester round-robin sequencer for a 16x16 single-port RAM
module ram16_arbiter #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            busy,
    output logic [DW-1:0]   ram_data_in,
    output logic [AW-1:0]   ram_addr_in,
    output logic            ram_cs,
    output logic            ram_w_en,
    output logic            ram_op_en,
    input  logic [DW-1:0]   ram_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            grant;
    logic            accept;
    logic            owner;
    logic            last_grant;
    logic            we_q;
    logic [2:0]      lat_cnt;
    logic            lat_done;
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;

    // The command of whichever requester the arbiter is pointing at this cycle.
    assign cmd_we    = grant ? req_we[1] : req_we[0];
    assign cmd_addr  = grant ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    assign cmd_wdata = grant ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

    // WAIT lasts RD_LAT cycles; the last one is where RAM data_out is valid.
    assign lat_done = (lat_cnt == 3'(RD_LAT - 1));
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration in IDLE (ready held low while reset is asserted) and next-state decode.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        grant     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    grant = ~last_grant;
                end else begin
                    grant = req_valid[1];
                end
                if (!reset && req_valid != 2'b00) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = we_q ? RESP : WAIT;
            WAIT:    if (lat_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, one-cycle RAM strobes, read-data capture and response pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            we_q        <= 1'b0;
            lat_cnt     <= 3'd0;
            ram_cs      <= 1'b0;
            ram_w_en    <= 1'b0;
            ram_op_en   <= 1'b0;
            ram_addr_in <= '0;
            ram_data_in <= '0;
            rsp_valid   <= 2'b00;
            rsp_rdata   <= '0;
        end else begin
            ram_cs    <= 1'b0;
            ram_w_en  <= 1'b0;
            ram_op_en <= 1'b0;
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner       <= grant;
                        last_grant  <= grant;
                        we_q        <= cmd_we;
                        ram_cs      <= 1'b1;
                        ram_w_en    <= cmd_we;
                        ram_op_en   <= ~cmd_we;
                        ram_addr_in <= cmd_addr;
                        if (cmd_we) begin
                            ram_data_in <= cmd_wdata;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= 3'd0;
                    if (we_q) begin
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        rsp_rdata <= '0;
                    end
                end
                WAIT: begin
                    if (lat_done) begin
                        rsp_valid <= owner ? 2'b10 : 2'b01;
                        rsp_rdata <= ram_data_out;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
